// File: rtl/hsdaoh_pkg.sv
// rtl/hsdaoh_pkg.sv - shared encodings for the hsdaoh test-pattern source
package hsdaoh_pkg;

    typedef enum logic [1:0] {
        PAT_COUNTER = 2'd0,
        PAT_LFSR    = 2'd1,
        PAT_WALK1   = 2'd2,
        PAT_CONST   = 2'd3
    } pat_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } gen_state_t;

    // Feedback taps at bits 15, 13, 12 and 10 give a maximal 65535-long sequence.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/hsdaoh_pat_step.sv
// rtl/hsdaoh_pat_step.sv - combinational next-pattern function for each pattern mode
module hsdaoh_pat_step
    import hsdaoh_pkg::*;
(
    input  pat_mode_t   mode,
    input  logic [15:0] pat,
    output logic [15:0] next_pat
);

    always_comb begin
        next_pat = pat;
        case (mode)
            PAT_COUNTER: next_pat = pat + 16'd1;
            PAT_LFSR:    next_pat = {pat[14:0], ^(pat & LFSR_TAPS)};
            PAT_WALK1:   next_pat = {pat[14:0], pat[15]};
            default:     next_pat = pat;
        endcase
    end

endmodule

// File: rtl/hsdaoh_pattern_gen.sv
// rtl/hsdaoh_pattern_gen.sv - rate-controlled test-pattern writer for the clk_data FIFO
module hsdaoh_pattern_gen
    import hsdaoh_pkg::*;
#(
    parameter int          DW        = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] CONST_VAL = 16'hA5A5,
    parameter int          RATE_W    = 8
) (
    input  logic              clk_data,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [RATE_W-1:0] rate_div,
    input  logic              clr_stats,
    input  logic              fifo_full,
    output logic [DW-1:0]     fifo_wdata,
    output logic              fifo_winc,
    output logic [15:0]       drop_cnt,
    output logic              overflow,
    output logic [31:0]       wr_cnt
);

    gen_state_t        state;
    pat_mode_t         mode_q;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] rate_cnt;
    logic [15:0]       pat;
    logic [15:0]       next_pat;
    logic [15:0]       seed;
    logic              tick;
    logic [15:0]       drop_base;
    logic [31:0]       wr_base;

    hsdaoh_pat_step u_step (
        .mode     (mode_q),
        .pat      (pat),
        .next_pat (next_pat)
    );

    always_comb begin
        case (mode_q)
            PAT_COUNTER: seed = 16'h0000;
            PAT_LFSR:    seed = LFSR_SEED;
            PAT_WALK1:   seed = 16'h0001;
            default:     seed = CONST_VAL;
        endcase
    end

    assign tick       = (state == ST_RUN) && (rate_cnt == '0);
    // Decided from live fifo_full so a sample is never written into a full FIFO.
    assign fifo_winc  = tick & ~fifo_full;
    assign fifo_wdata = pat;

    // Clearing first lets a same-cycle drop or write count as the first event.
    assign drop_base = clr_stats ? 16'h0000 : drop_cnt;
    assign wr_base   = clr_stats ? 32'h0 : wr_cnt;

    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= PAT_COUNTER;
            rate_q   <= '0;
            rate_cnt <= '0;
            pat      <= 16'h0000;
            drop_cnt <= 16'h0000;
            overflow <= 1'b0;
            wr_cnt   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        mode_q <= pat_mode_t'(mode);
                        rate_q <= rate_div;
                        state  <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    pat      <= seed;
                    rate_cnt <= '0;
                    state    <= enable ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (tick) begin
                        rate_cnt <= rate_q;
                        pat      <= next_pat;
                    end else begin
                        rate_cnt <= rate_cnt - 1'b1;
                    end
                    if (!enable)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (tick && fifo_full) begin
                drop_cnt <= (drop_base == 16'hFFFF) ? drop_base : drop_base + 16'd1;
                overflow <= 1'b1;
            end else begin
                drop_cnt <= drop_base;
                overflow <= overflow & ~clr_stats;
            end
            wr_cnt <= fifo_winc ? wr_base + 32'd1 : wr_base;
        end
    end

endmodule

// File: tb/tb_hsdaoh_pattern_gen.sv
// tb/tb_hsdaoh_pattern_gen.sv - self-checking bench for hsdaoh_pattern_gen
module tb_hsdaoh_pattern_gen;

    logic        clk_data = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  rate_div = 8'd0;
    logic        clr_stats = 1'b0;
    logic        fifo_full = 1'b0;
    logic [15:0] fifo_wdata;
    logic        fifo_winc;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic [31:0] wr_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    hsdaoh_pattern_gen dut (
        .clk_data   (clk_data),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .rate_div   (rate_div),
        .clr_stats  (clr_stats),
        .fifo_full  (fifo_full),
        .fifo_wdata (fifo_wdata),
        .fifo_winc  (fifo_winc),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow),
        .wr_cnt     (wr_cnt)
    );

    always #5 clk_data = ~clk_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int p);
        int fb;
        fb = ((p >> 15) ^ (p >> 13) ^ (p >> 12) ^ (p >> 10)) & 1;
        return ((p << 1) & 32'hFFFF) | fb;
    endfunction

    function automatic int pat_next(input int m, input int p);
        case (m)
            0: return (p + 1) % 65536;
            1: return lfsr_next(p);
            2: return ((p << 1) & 32'hFFFF) | (p >> 15);
            default: return p;
        endcase
    endfunction

    // Reference model: phase 0 idle, 1 prime, 2 run; m_k counts cycles spent in run.
    int          m_phase, m_mode, m_rate, m_k, m_pat;
    int          m_drop;
    logic        m_ovf;
    logic [31:0] m_wr;

    function automatic logic m_tick();
        return (m_phase == 2) && ((m_k % (m_rate + 1)) == 0);
    endfunction

    always @(posedge clk_data or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_mode = 0; m_rate = 0; m_k = 0; m_pat = 0;
            m_drop = 0; m_ovf = 1'b0; m_wr = 32'h0;
        end else begin
            logic t;
            t = m_tick();
            if (clr_stats) begin
                m_drop = 0; m_ovf = 1'b0; m_wr = 32'h0;
            end
            if (t && fifo_full) begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1'b1;
            end
            if (t && !fifo_full) m_wr = m_wr + 32'd1;
            case (m_phase)
                0: if (enable) begin
                    m_mode = int'(mode); m_rate = int'(rate_div); m_phase = 1;
                end
                1: begin
                    case (m_mode)
                        0: m_pat = 0;
                        1: m_pat = 16'hACE1;
                        2: m_pat = 1;
                        default: m_pat = 16'hA5A5;
                    endcase
                    m_k = 0;
                    m_phase = enable ? 2 : 0;
                end
                default: begin
                    if (t) m_pat = pat_next(m_mode, m_pat);
                    m_k++;
                    if (!enable) m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk_data) begin
        if (!rst) begin
            chk("winc", 32'(fifo_winc), 32'(m_tick() && !fifo_full));
            chk("wdata", 32'(fifo_wdata), 32'(m_pat));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("wr_cnt", wr_cnt, m_wr);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_data);
        #1;
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
    endtask

    initial begin
        int p, first_ret, cnt;
        logic zero_seen;
        logic [15:0] seen [4];

        // Model pins: LFSR sequence start, period and zero-freedom.
        chk("lfsr_step1", 32'(lfsr_next(16'hACE1)), 32'h59C3);
        p = 16'hACE1; first_ret = 0; zero_seen = 1'b0;
        for (int n = 1; n <= 65535; n++) begin
            p = lfsr_next(p);
            if (p == 0) zero_seen = 1'b1;
            if (p == 16'hACE1 && first_ret == 0) first_ret = n;
        end
        chk("lfsr_period", 32'(first_ret), 32'd65535);
        chk("lfsr_zero", 32'(zero_seen), 32'd0);

        step(3);
        chk("rst_wdata", 32'(fifo_wdata), 32'h0);
        chk("rst_winc", 32'(fifo_winc), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_wr", wr_cnt, 32'h0);
        rst = 1'b0;

        // Counter, every cycle.
        mode = 2'd0; rate_div = 8'd0; enable = 1'b1;
        step(2);
        chk("t1_first_winc", 32'(fifo_winc), 32'd1);
        chk("t1_first_wdata", 32'(fifo_wdata), 32'd0);
        step(20);
        chk("t1_wdata20", 32'(fifo_wdata), 32'd20);
        chk("t1_wr20", wr_cnt, 32'd20);
        enable = 1'b0;
        step(1);
        chk("t1_idle_winc", 32'(fifo_winc), 32'd0);

        // Divided rate.
        pulse_clr();
        rate_div = 8'd3; enable = 1'b1;
        step(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) chk("t2_first_strobe", 32'(fifo_winc), 32'd1);
            if (fifo_winc) begin
                if (cnt < 4) seen[cnt] = fifo_wdata;
                cnt++;
            end
            step(1);
        end
        chk("t2_strobes", 32'(cnt), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_seq", 32'(seen[i]), 32'(i));
        enable = 1'b0;
        step(1);

        // Drops mid-run.
        pulse_clr();
        rate_div = 8'd0; enable = 1'b1;
        step(12);
        fifo_full = 1'b1;
        step(5);
        fifo_full = 1'b0;
        chk("t3_drop", 32'(drop_cnt), 32'd5);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_resume", 32'(fifo_wdata), 32'd15);
        enable = 1'b0;
        step(1);

        // LFSR on the DUT.
        pulse_clr();
        mode = 2'd1; enable = 1'b1;
        step(2);
        chk("t4_first", 32'(fifo_wdata), 32'hACE1);
        step(1);
        chk("t4_second", 32'(fifo_wdata), 32'h59C3);
        step(300);
        enable = 1'b0;
        step(1);

        // Saturating drops and clear/event collisions.
        pulse_clr();
        mode = 2'd0; fifo_full = 1'b1; enable = 1'b1;
        step(2);
        step(65600);
        chk("t5_sat", 32'(drop_cnt), 32'hFFFF);
        chk("t5_ovf", 32'(overflow), 32'd1);
        clr_stats = 1'b1;
        step(1);
        chk("t5_clr_drop", 32'(drop_cnt), 32'd1);
        chk("t5_clr_ovf", 32'(overflow), 32'd1);
        fifo_full = 1'b0;
        step(1);
        clr_stats = 1'b0;
        chk("t5_clr_wr", wr_cnt, 32'd1);
        chk("t5_clr_drop0", 32'(drop_cnt), 32'd0);
        enable = 1'b0;
        step(1);

        // Re-enable with a new mode, then asynchronous reset mid-run.
        enable = 1'b1;
        step(7);
        enable = 1'b0;
        mode = 2'd2;
        step(1);
        chk("t6_off_winc", 32'(fifo_winc), 32'd0);
        step(2);
        enable = 1'b1;
        step(1);
        chk("t6_prime_winc", 32'(fifo_winc), 32'd0);
        step(1);
        chk("t6_w0", 32'(fifo_wdata), 32'h0001);
        step(1);
        chk("t6_w1", 32'(fifo_wdata), 32'h0002);
        step(1);
        chk("t6_w2", 32'(fifo_wdata), 32'h0004);
        step(3);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_winc", 32'(fifo_winc), 32'd0);
        chk("t6_rst_wdata", 32'(fifo_wdata), 32'd0);
        chk("t6_rst_wr", wr_cnt, 32'd0);
        chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        enable = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
